// File: rtl/fifo_sched.sv
// -----------------------------------------------------------------------------
// fifo_sched
//
// Access scheduler sitting in front of a 16-entry x 8-bit synchronous FIFO.
// Two producers share the FIFO write port under round-robin arbitration with a
// burst limit; one consumer reads. Reads win over writes, except that after
// RMAX consecutive reads a pending eligible write is given exactly one slot.
// At most one FIFO operation is issued per cycle, so an ack always means the
// FIFO stored the word at that edge.
//
// Parameters
//   BURST   max consecutive accepted writes by one producer while the other
//           producer is also requesting (1..15)
//   RMAX    max consecutive reads while a write is eligible (1..15)
//
// Ports
//   ck               clock, rising edge
//   rst              asynchronous active-low reset
//   req0/req1        producer write requests (held with data until acked)
//   din0/din1        producer write data
//   ack0/ack1        combinational: word accepted at this rising edge
//   rreq             consumer read request
//   rvalid           registered: rdata valid this cycle
//   rdata            pass-through of f_dout
//   f_din/f_wen/f_ren  FIFO write data, write enable, read enable
//   f_dout           FIFO read data (registered inside the FIFO)
//   f_empty/f_full   FIFO status flags
// -----------------------------------------------------------------------------
module fifo_sched #(
   parameter int BURST = 4,
   parameter int RMAX  = 3
) (
   input  logic       ck,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] din0,
   input  logic [7:0] din1,
   output logic       ack0,
   output logic       ack1,
   input  logic       rreq,
   output logic       rvalid,
   output logic [7:0] rdata,
   output logic [7:0] f_din,
   output logic       f_wen,
   output logic       f_ren,
   input  logic [7:0] f_dout,
   input  logic       f_empty,
   input  logic       f_full
);

   localparam logic [3:0] BURST_C = 4'(BURST);
   localparam logic [3:0] RMAX_C  = 4'(RMAX);

   // state
   logic       gnt_reg;
   logic       gnt_next;
   logic [3:0] bcnt_reg;
   logic [3:0] bcnt_next;
   logic [3:0] rstk_reg;
   logic [3:0] rstk_next;
   logic       rvalid_reg;

   // decision signals
   logic [1:0] req;
   logic [1:0] ack;
   logic       req_gnt;
   logic       req_oth;
   logic       owner;
   logic       wr_elig;
   logic       rd_go;
   logic       wr_go;

   assign req     = {req1, req0};
   assign req_gnt = req[gnt_reg];
   assign req_oth = req[~gnt_reg];

   // The current owner keeps the port until its burst is used up, but only
   // while the other producer is actually waiting; a lone requester is never
   // throttled.
   always_comb begin
      owner = gnt_reg;
      if (req_gnt && ((bcnt_reg < BURST_C) || !req_oth)) begin
         owner = gnt_reg;
      end else if (req_oth) begin
         owner = ~gnt_reg;
      end
   end

   assign wr_elig = (req0 | req1) & ~f_full;

   // Reads have priority until the streak limit is hit with a write waiting.
   // Both go signals are gated by rst so nothing reaches the FIFO in reset.
   assign rd_go = rst & rreq & ~f_empty & ~((rstk_reg == RMAX_C) & wr_elig);
   assign wr_go = rst & ~rd_go & req[owner] & ~f_full;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ack
         assign ack[gi] = wr_go & (owner == 1'(gi));
      end
   endgenerate

   assign ack0   = ack[0];
   assign ack1   = ack[1];
   assign f_wen  = wr_go;
   assign f_ren  = rd_go;
   // In reset owner may still point at producer 1; din0 is presented instead.
   assign f_din  = (rst & owner) ? din1 : din0;
   assign rdata  = f_dout;
   assign rvalid = rvalid_reg;

   // next-state logic
   always_comb begin
      gnt_next  = gnt_reg;
      bcnt_next = bcnt_reg;
      if (wr_go) begin
         if (owner == gnt_reg) begin
            bcnt_next = (bcnt_reg >= BURST_C) ? BURST_C : bcnt_reg + 4'd1;
         end else begin
            gnt_next  = owner;
            bcnt_next = 4'd1;
         end
      end

      // any cycle without a read breaks the streak
      if (rd_go) begin
         rstk_next = (rstk_reg >= RMAX_C) ? RMAX_C : rstk_reg + 4'd1;
      end else begin
         rstk_next = 4'd0;
      end
   end

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         gnt_reg    <= 1'b0;
         bcnt_reg   <= 4'd0;
         rstk_reg   <= 4'd0;
         rvalid_reg <= 1'b0;
      end else begin
         gnt_reg    <= gnt_next;
         bcnt_reg   <= bcnt_next;
         rstk_reg   <= rstk_next;
         // FIFO output buffer loads on the same edge, so rdata lines up
         rvalid_reg <= rd_go;
      end
   end

endmodule

// File: tb/tb_fifo_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_sched
//
// Directed bench for fifo_sched with a behavioural 16 x 8 synchronous FIFO
// attached. Inputs change on the falling edge; outputs are sampled 1-2 ns
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_sched;

   logic       ck;
   logic       rst;
   logic       req0, req1;
   logic [7:0] din0, din1;
   logic       ack0, ack1;
   logic       rreq;
   logic       rvalid;
   logic [7:0] rdata;
   logic [7:0] f_din;
   logic       f_wen, f_ren;
   logic [7:0] f_dout;
   logic       f_empty, f_full;

   int checks = 0;
   int errors = 0;

   logic [7:0] expq [$];

   fifo_sched #(.BURST(4), .RMAX(3)) dut (
      .ck      (ck),
      .rst     (rst),
      .req0    (req0),
      .req1    (req1),
      .din0    (din0),
      .din1    (din1),
      .ack0    (ack0),
      .ack1    (ack1),
      .rreq    (rreq),
      .rvalid  (rvalid),
      .rdata   (rdata),
      .f_din   (f_din),
      .f_wen   (f_wen),
      .f_ren   (f_ren),
      .f_dout  (f_dout),
      .f_empty (f_empty),
      .f_full  (f_full)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // behavioural FIFO: synchronous reset, one operation per edge,
   // registered output buffer
   logic [7:0] mem [16];
   int         cnt = 0;
   int         wp  = 0;
   int         rp  = 0;
   logic [7:0] dout_q = 8'h00;

   always @(posedge ck) begin
      if (!rst) begin
         cnt <= 0;
         wp  <= 0;
         rp  <= 0;
      end else if (f_wen && cnt < 16) begin
         mem[wp] <= f_din;
         wp      <= (wp + 1) % 16;
         cnt     <= cnt + 1;
      end else if (f_ren && cnt > 0) begin
         dout_q <= mem[rp];
         rp     <= (rp + 1) % 16;
         cnt    <= cnt - 1;
      end
   end

   assign f_dout  = dout_q;
   assign f_empty = (cnt == 0);
   assign f_full  = (cnt == 16);

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   // read n words with rreq held, comparing against the expected queue
   task automatic drain(input int n);
      logic [7:0] e;
      rreq = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         chk("drain_ren", 8'(f_ren), 8'h01);
         @(negedge ck);
         #1;
         e = expq.pop_front();
         chk("drain_rvalid", 8'(rvalid), 8'h01);
         chk("drain_rdata", rdata, e);
         $display("read  %02h (expected %02h)", rdata, e);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge ck);
      rst = 1'b1;
   endtask

   initial begin
      logic [15:0] pat;
      logic [7:0]  n0, n1, e, exp_din;
      logic        isw, prev_r;
      int          k;

      // ---------------- reset state ----------------
      rst  = 1'b0;
      req0 = 1'b1;
      req1 = 1'b0;
      din0 = 8'h77;
      din1 = 8'h88;
      rreq = 1'b1;
      #3;
      chk("rst_ack0", 8'(ack0), 8'h00);
      chk("rst_wen", 8'(f_wen), 8'h00);
      chk("rst_ren", 8'(f_ren), 8'h00);
      chk("rst_rvalid", 8'(rvalid), 8'h00);
      chk("rst_fdin", f_din, 8'h77);
      @(negedge ck);
      rst  = 1'b1;
      rreq = 1'b0;

      // ---------------- fill with req0 only ----------------
      for (int i = 0; i < 16; i++) begin
         din0 = 8'(i);
         #1;
         chk("fill_ack0", 8'(ack0), 8'h01);
         chk("fill_fdin", f_din, 8'(i));
         expq.push_back(8'(i));
         $display("write %02h by producer 0", din0);
         @(negedge ck);
      end
      din0 = 8'h10;
      #1;
      chk("fill_full", 8'(f_full), 8'h01);
      chk("fill17_ack0", 8'(ack0), 8'h00);
      chk("fill17_wen", 8'(f_wen), 8'h00);
      @(negedge ck);
      #1;
      chk("fill18_ack0", 8'(ack0), 8'h00);
      drain(16);
      #1;
      chk("empty_ren", 8'(f_ren), 8'h00);
      @(negedge ck);
      #1;
      chk("empty_rvalid", 8'(rvalid), 8'h00);
      rreq = 1'b0;

      // ---------------- round-robin with burst 4 ----------------
      do_reset();
      pat  = 16'b1111_0000_1111_0000;   // bit k = 1 -> producer 1 acked
      n0   = 8'h00;
      n1   = 8'h00;
      req0 = 1'b1;
      req1 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din0 = 8'h10 + n0;
         din1 = 8'h20 + n1;
         #1;
         exp_din = pat[i] ? din1 : din0;
         chk("rr_ack1", 8'(ack1), 8'(pat[i]));
         chk("rr_ack0", 8'(ack0), 8'(!pat[i]));
         chk("rr_fdin", f_din, exp_din);
         expq.push_back(exp_din);
         $display("write %02h by producer %0d", exp_din, pat[i]);
         if (pat[i]) n1++; else n0++;
         @(negedge ck);
      end
      din0 = 8'h18;
      din1 = 8'h28;
      #1;
      chk("full_flag", 8'(f_full), 8'h01);
      chk("full_ack0", 8'(ack0), 8'h00);
      chk("full_ack1", 8'(ack1), 8'h00);
      @(negedge ck);
      #1;
      chk("full2_ack0", 8'(ack0), 8'h00);
      chk("full2_ack1", 8'(ack1), 8'h00);
      // one read frees a slot; owner after the 1,1,1,1 burst is producer 0
      rreq = 1'b1;
      #1;
      chk("full_rd_ren", 8'(f_ren), 8'h01);
      chk("full_rd_ack0", 8'(ack0), 8'h00);
      chk("full_rd_ack1", 8'(ack1), 8'h00);
      @(negedge ck);
      rreq = 1'b0;
      #1;
      e = expq.pop_front();
      chk("full_rd_rvalid", 8'(rvalid), 8'h01);
      chk("full_rd_rdata", rdata, e);
      chk("refill_ack0", 8'(ack0), 8'h01);
      chk("refill_ack1", 8'(ack1), 8'h00);
      chk("refill_fdin", f_din, 8'h18);
      expq.push_back(8'h18);
      @(negedge ck);
      req0 = 1'b0;
      req1 = 1'b0;
      #1;
      chk("refull_flag", 8'(f_full), 8'h01);
      drain(16);
      rreq = 1'b0;

      // ---------------- read streak limit ----------------
      @(negedge ck);
      req0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din0 = 8'h30 + 8'(i);
         #1;
         chk("pre_ack0", 8'(ack0), 8'h01);
         expq.push_back(din0);
         @(negedge ck);
      end
      rreq   = 1'b1;
      k      = 8;
      prev_r = 1'b0;
      for (int c = 0; c < 12; c++) begin
         isw  = ((c % 4) == 3);
         din0 = 8'h30 + 8'(k);
         #1;
         chk("stk_ren", 8'(f_ren), 8'(!isw));
         chk("stk_wen", 8'(f_wen), 8'(isw));
         chk("stk_rvalid", 8'(rvalid), 8'(prev_r));
         if (prev_r) begin
            e = expq.pop_front();
            chk("stk_rdata", rdata, e);
         end
         if (isw) begin
            expq.push_back(din0);
            k++;
         end
         $display("cycle %0d op %s", c, isw ? "W" : "R");
         prev_r = !isw;
         @(negedge ck);
      end
      req0 = 1'b0;
      #1;
      chk("stk_end_rvalid", 8'(rvalid), 8'h00);
      drain(2);

      // ---------------- read on empty, then single write ----------------
      #1;
      chk("emp_ren", 8'(f_ren), 8'h00);
      @(negedge ck);
      #1;
      chk("emp_ren2", 8'(f_ren), 8'h00);
      chk("emp_rvalid", 8'(rvalid), 8'h00);
      req0 = 1'b1;
      din0 = 8'hA5;
      #1;
      chk("a5_ack0", 8'(ack0), 8'h01);
      chk("a5_ren", 8'(f_ren), 8'h00);
      @(negedge ck);
      req0 = 1'b0;
      #1;
      chk("a5_rd_ren", 8'(f_ren), 8'h01);
      chk("a5_rd_rvalid", 8'(rvalid), 8'h00);
      @(negedge ck);
      #1;
      chk("a5_rvalid", 8'(rvalid), 8'h01);
      chk("a5_rdata", rdata, 8'hA5);
      chk("a5_ren_after", 8'(f_ren), 8'h00);
      rreq = 1'b0;

      // ---------------- reset mid-burst ----------------
      @(negedge ck);
      req1 = 1'b1;
      din1 = 8'h51;
      #1;
      chk("mb_ack1_a", 8'(ack1), 8'h01);
      @(negedge ck);
      din1 = 8'h52;
      #1;
      chk("mb_ack1_b", 8'(ack1), 8'h01);
      @(negedge ck);
      req1 = 1'b0;
      rreq = 1'b1;
      #1;
      chk("mb_ren", 8'(f_ren), 8'h01);
      @(negedge ck);
      req0 = 1'b1;
      req1 = 1'b1;
      din0 = 8'h60;
      din1 = 8'h61;
      #1;
      chk("mb_rvalid", 8'(rvalid), 8'h01);
      chk("mb_rdata", rdata, 8'h51);
      chk("mb_ren2", 8'(f_ren), 8'h01);
      rst = 1'b0;
      #1;
      chk("mbr_rvalid", 8'(rvalid), 8'h00);
      chk("mbr_ren", 8'(f_ren), 8'h00);
      chk("mbr_wen", 8'(f_wen), 8'h00);
      chk("mbr_ack0", 8'(ack0), 8'h00);
      chk("mbr_ack1", 8'(ack1), 8'h00);
      chk("mbr_fdin", f_din, 8'h60);
      @(negedge ck);
      rst  = 1'b1;
      rreq = 1'b0;
      #1;
      chk("post_ack0", 8'(ack0), 8'h01);
      chk("post_ack1", 8'(ack1), 8'h00);
      chk("post_fdin", f_din, 8'h60);
      @(negedge ck);
      #1;
      chk("post2_ack0", 8'(ack0), 8'h01);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge ck);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_sched.md
# fifo_sched

Access scheduler for the 16-entry, 8-bit synchronous FIFO. It shares the FIFO write port between two producers using round-robin with a burst limit, and serves one consumer. Reads take priority, but a read-streak limit stops writers from starving. It drives the FIFO's Din/Wen/Ren directly, watches Fempty/Ffull, and returns per-producer acks and a read-data-valid strobe.

## Interface
- BURST, 4: maximum consecutive accepted writes by one producer while the other is requesting; legal range 1..15.
- RMAX, 3: maximum consecutive reads while a write is eligible; legal range 1..15.
- ck  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  producer write request; must be held with data until acked.
- din0, din1  in  8  producer write data.
- ack0, ack1  out  1  combinational; the word is accepted at this rising edge.
- rreq  in  1  consumer read request.
- rvalid  out  1  registered; rdata is valid this cycle.
- rdata  out  8  pass-through of f_dout.
- f_din  out  8  to FIFO Din.
- f_wen  out  1  to FIFO Wen.
- f_ren  out  1  to FIFO Ren.
- f_dout  in  8  from FIFO Dout.
- f_empty, f_full  in  1  from FIFO Fempty/Ffull.

## Operation
- State registers:
  - gnt (1 bit): current write owner.
  - bcnt (4 bits): burst count for gnt; saturates at BURST.
  - rstk (4 bits): read streak; saturates at RMAX.
  - rvalid.
- wr_elig = (req0 | req1) & ~f_full.
- Read decision: rd_go = rreq & ~f_empty & ~(rstk == RMAX & wr_elig).
- Owner selection (combinational):
  - owner = gnt if req[gnt] & (bcnt < BURST | ~req[~gnt]).
  - Otherwise owner = ~gnt if req[~gnt].
  - Otherwise owner = gnt.
- Write decision: wr_go = ~rd_go & req[owner] & ~f_full.
- Outputs:
  - f_ren = rd_go.
  - f_wen = wr_go.
  - f_din = owner ? din1 : din0.
  - ackN = wr_go & (owner == N).
- At most one of f_ren / f_wen is high in any cycle. This matches the FIFO's one-operation-per-cycle behaviour, so an ack always means the FIFO stored the word.
- Grant update on wr_go:
  - owner == gnt: bcnt <= min(bcnt + 1, BURST).
  - Otherwise: gnt <= owner, bcnt <= 1.
- No wr_go: gnt and bcnt hold. bcnt is not cleared by idle cycles.
- Streak update:
  - rd_go: rstk <= min(rstk + 1, RMAX).
  - Any cycle without rd_go: rstk <= 0.
- rvalid <= rd_go. The FIFO's output buffer loads at that same edge, so rdata is correct while rvalid = 1 and holds until the next read.
- While rst is low:
  - Registers are cleared immediately: gnt = 0, bcnt = 0, rstk = 0, rvalid = 0.
  - f_wen, f_ren, ack0 and ack1 are forced to 0 combinationally.
  - f_din follows din0.
- rst must be held low for at least one ck edge so that the FIFO's synchronous reset also takes effect.

## Timing
- Write latency: ack is in the same cycle as an eligible request. The word is in the FIFO after that edge, and f_empty deasserts at the same edge.
- Read latency: 1 cycle from the rd_go edge to rvalid.
- Full: f_full = 1 gives no acks, and the burst/owner state holds. A read that cycle drops f_full, so a write can be accepted on the next cycle.
- Empty: f_empty = 1 gives no f_ren and rvalid = 0 on the next cycle, whatever rreq does. Writes proceed and rstk is cleared.
- Simultaneous rreq and write request:
  - The read wins unless rstk == RMAX.
  - When rstk == RMAX, exactly one write slot is granted, then rstk returns to 0.
- Request withdrawn before ack: legal. No state changes.
- Reset mid-burst: the next grant after release goes to req0 first if both are requesting, with bcnt = 0.

## Test plan
- Reset, then req0 = 1 with din0 = 0x00..0x0F over 16 cycles, no reads:
  - ack0 is high for 16 cycles and f_full = 1 after the 16th edge.
  - ack0 = 0 from cycle 17 on.
- Both requesting, BURST = 4, no reads, FIFO empty:
  - ack sequence is 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1.
  - The FIFO then holds data in that order.
- Prefill 8 words, then rreq = 1 and req0 = 1 continuously, RMAX = 3:
  - Per-cycle op pattern is R,R,R,W,R,R,R,W…
  - rvalid trails each R by one cycle, and rdata matches write order.
- FIFO empty, rreq = 1, then one write of 0xA5:
  - No f_ren and rvalid = 0 while empty.
  - f_ren is high the cycle after the write; rvalid = 1 with rdata = 0xA5 one cycle later.
- FIFO full and both requesting, with one read:
  - No acks while full.
  - The read frees a slot, the next cycle acks the owner, and f_full reasserts.
- Assert rst mid-burst (gnt = 1, bcnt = 2, rvalid = 1):
  - Outputs drop to 0 immediately while rst is low.
  - After release with both requesting, the first ack is ack0.
